// File: rtl/vga_pkg.sv
// Shared VGA/trace definitions: per-channel trace colours, channel limit and
// the sample-writer state encoding.
package vga_pkg;

  localparam int MAX_CH = 4;

  localparam logic [11:0] TRACE_COLOR [MAX_CH] = '{12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } wr_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between pixel-pipeline stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/trace_bank_ram.sv
// Two-bank sample store for one channel: one write port, two registered read
// ports (current column and previous column) on the displayed bank.
module trace_bank_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 12,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rbank,
  input  logic [AW-1:0]     raddr_cur,
  input  logic [AW-1:0]     raddr_prev,
  output logic [DATA_W-1:0] rdata_cur,
  output logic [DATA_W-1:0] rdata_prev
);

  logic [DATA_W-1:0] mem_r [2*DEPTH];

  // Sample storage is deliberately unreset; an empty front length hides it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[{wbank, waddr}] <= wdata;
    end
    rdata_cur  <= mem_r[{rbank, raddr_cur}];
    rdata_prev <= mem_r[{rbank, raddr_prev}];
  end

endmodule

// File: rtl/draw_trace.sv
// Oscilloscope-style trace overlay: double-buffered sample capture per channel
// and a two-stage pixel pipeline that draws connected vertical segments.
module draw_trace
  import vga_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          DEPTH        = 256,
  parameter int          DATA_W       = 12,
  parameter logic [10:0] H_POS        = 11'd32,
  parameter logic [10:0] V_POS        = 11'd560,
  parameter logic [10:0] LENGTH       = 11'd512,
  parameter logic [10:0] HEIGHT       = 11'd512,
  parameter int          H_DECIM_LOG2 = 1,
  localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  vga_if.in                        in,
  vga_if.out                       out,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_last,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic signed [10:0]       x_off,
  input  logic signed [10:0]       y_off,
  input  logic [3:0]               scale_shift
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  wr_state_t         state_r     [NUM_CH];
  logic [LW-1:0]     wptr_r      [NUM_CH];
  logic [LW-1:0]     back_len_r  [NUM_CH];
  logic [LW-1:0]     front_len_r [NUM_CH];
  logic [NUM_CH-1:0] bank_sel_r;
  logic              vblnk_prev_r;
  logic              vblnk_rise_s;
  logic [NUM_CH-1:0] full_s, take_s, we_s, ready_s;

  assign vblnk_rise_s = in.vblnk & ~vblnk_prev_r;
  assign wr_ready     = ready_s[wr_ch];

  // Per-channel beat acceptance; a full channel still takes the closing wr_last beat.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      full_s[c]  = wptr_r[c][AW];
      ready_s[c] = (state_r[c] == FILL) && !full_s[c];
      take_s[c]  = wr_valid && (wr_ch == CH_W'(c)) && (state_r[c] == FILL) && (!full_s[c] || wr_last);
      we_s[c]    = take_s[c] && !full_s[c];
    end
  end

  // Writer FSMs: fill the back bank, then wait for a vblank rising edge to swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel_r   <= '0;
      vblnk_prev_r <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        state_r[c]     <= FILL;
        wptr_r[c]      <= '0;
        back_len_r[c]  <= '0;
        front_len_r[c] <= '0;
      end
    end else begin
      vblnk_prev_r <= in.vblnk;
      for (int c = 0; c < NUM_CH; c++) begin
        case (state_r[c])
          FILL: begin
            if (take_s[c]) begin
              if (we_s[c]) begin
                wptr_r[c] <= wptr_r[c] + LW'(1);
              end
              if (wr_last) begin
                back_len_r[c] <= full_s[c] ? wptr_r[c] : wptr_r[c] + LW'(1);
                state_r[c]    <= PENDING;
              end
            end
          end
          PENDING: begin
            if (vblnk_rise_s) begin
              bank_sel_r[c]  <= ~bank_sel_r[c];
              front_len_r[c] <= back_len_r[c];
              wptr_r[c]      <= '0;
              state_r[c]     <= FILL;
            end
          end
          default: state_r[c] <= FILL;
        endcase
      end
    end
  end

  logic signed [11:0] h_rel_s, col_s, i_r;
  logic [AW-1:0]      rd_addr_cur_s, rd_addr_prev_s;
  logic               in_win_s, win_r;
  logic [DATA_W-1:0]  rd_cur_s  [NUM_CH];
  logic [DATA_W-1:0]  rd_prev_s [NUM_CH];

  // Stage-1 address: column index relative to the window plus horizontal offset.
  always_comb begin
    h_rel_s        = $signed({1'b0, in.hcount}) - $signed({1'b0, H_POS});
    col_s          = (h_rel_s >>> H_DECIM_LOG2) + $signed({x_off[10], x_off});
    rd_addr_cur_s  = col_s[AW-1:0];
    rd_addr_prev_s = col_s[AW-1:0] - AW'(1);
    in_win_s       = (in.hcount >= H_POS)
                  && ({1'b0, in.hcount} < ({1'b0, H_POS} + {1'b0, LENGTH}))
                  && (in.vcount <= V_POS)
                  && (({1'b0, in.vcount} + {1'b0, HEIGHT}) > {1'b0, V_POS});
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    trace_bank_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk        (clk),
      .we         (we_s[g]),
      .wbank      (~bank_sel_r[g]),
      .waddr      (wptr_r[g][AW-1:0]),
      .wdata      (wr_data),
      .rbank      (bank_sel_r[g]),
      .raddr_cur  (rd_addr_cur_s),
      .raddr_prev (rd_addr_prev_s),
      .rdata_cur  (rd_cur_s[g]),
      .rdata_prev (rd_prev_s[g])
    );
  end

  logic [10:0] hcount_d1_r, vcount_d1_r;
  logic        hsync_d1_r, vsync_d1_r, hblnk_d1_r, vblnk_d1_r;
  logic [11:0] rgb_d1_r, rgb_s;
  logic signed [12:0] v_s;
  logic signed [12:0] y_cur_s  [NUM_CH];
  logic signed [12:0] y_prev_s [NUM_CH];
  logic [NUM_CH-1:0]  in_seg_s, lit_s;

  // Stage-2 hit test: lit when vcount sits between y(i-1) and y(i) inclusive.
  always_comb begin
    v_s = $signed({2'b00, vcount_d1_r});
    for (int c = 0; c < NUM_CH; c++) begin
      y_cur_s[c]  = $signed({2'b00, V_POS}) - $signed(13'(rd_cur_s[c] >> scale_shift))
                  - $signed({{2{y_off[10]}}, y_off});
      y_prev_s[c] = $signed({2'b00, V_POS}) - $signed(13'(rd_prev_s[c] >> scale_shift))
                  - $signed({{2{y_off[10]}}, y_off});
      in_seg_s[c] = (y_cur_s[c] <= y_prev_s[c])
                  ? ((v_s >= y_cur_s[c]) && (v_s <= y_prev_s[c]))
                  : ((v_s >= y_prev_s[c]) && (v_s <= y_cur_s[c]));
      lit_s[c]    = win_r && ch_en[c] && (i_r > 12'sd0)
                  && ($signed({i_r[11], i_r}) < $signed(13'(front_len_r[c])))
                  && in_seg_s[c];
    end
    rgb_s = rgb_d1_r;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      rgb_s = lit_s[c] ? TRACE_COLOR[c] : rgb_s;
    end
  end

  // Two-stage timing pipeline with the overlay colour muxed in at stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_r         <= '0;
      win_r       <= 1'b0;
      hcount_d1_r <= '0;
      vcount_d1_r <= '0;
      hsync_d1_r  <= 1'b0;
      vsync_d1_r  <= 1'b0;
      hblnk_d1_r  <= 1'b0;
      vblnk_d1_r  <= 1'b0;
      rgb_d1_r    <= '0;
      out.hcount  <= '0;
      out.vcount  <= '0;
      out.hsync   <= 1'b0;
      out.vsync   <= 1'b0;
      out.hblnk   <= 1'b0;
      out.vblnk   <= 1'b0;
      out.rgb     <= '0;
    end else begin
      i_r         <= col_s;
      win_r       <= in_win_s;
      hcount_d1_r <= in.hcount;
      vcount_d1_r <= in.vcount;
      hsync_d1_r  <= in.hsync;
      vsync_d1_r  <= in.vsync;
      hblnk_d1_r  <= in.hblnk;
      vblnk_d1_r  <= in.vblnk;
      rgb_d1_r    <= in.rgb;
      out.hcount  <= hcount_d1_r;
      out.vcount  <= vcount_d1_r;
      out.hsync   <= hsync_d1_r;
      out.vsync   <= vsync_d1_r;
      out.hblnk   <= hblnk_d1_r;
      out.vblnk   <= vblnk_d1_r;
      out.rgb     <= rgb_s;
    end
  end

endmodule

// File: tb/tb_draw_trace.sv
// Directed bench for draw_trace: capture, swap timing, segment drawing,
// channel priority, overflow and reset-while-pending behaviour.
module tb_draw_trace;
  import vga_pkg::*;

  localparam logic [11:0] BG  = 12'h123;
  localparam logic [11:0] C0  = 12'hFF0;
  localparam logic [11:0] C1  = 12'h0FF;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_valid, wr_ready, wr_ch, wr_last;
  logic [11:0]        wr_data;
  logic [1:0]         ch_en;
  logic signed [10:0] x_off, y_off;
  logic [3:0]         scale_shift;
  int                 errors = 0;
  int                 checks = 0;

  vga_if vin ();
  vga_if vout ();

  always #5 clk = ~clk;

  draw_trace dut (
    .clk         (clk),
    .rst         (rst),
    .in          (vin.in),
    .out         (vout.out),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_ch       (wr_ch),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .ch_en       (ch_en),
    .x_off       (x_off),
    .y_off       (y_off),
    .scale_shift (scale_shift)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic [11:0] exp);
    @(negedge clk);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.rgb    = BG;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, {20'd0, vout.rgb}, {20'd0, exp});
  endtask

  task automatic write_beat(input logic ch, input logic [11:0] d, input logic last);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_data  = d;
    wr_last  = last;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic vblank_pulse();
    @(negedge clk);
    vin.vblnk = 1'b1;
    @(negedge clk);
    vin.vblnk = 1'b0;
  endtask

  task automatic ready_check(input string tag, input logic ch, input logic exp);
    @(negedge clk);
    wr_ch = ch;
    #1;
    check(tag, {31'd0, wr_ready}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; wr_ch = 1'b0; wr_data = 12'd0; wr_last = 1'b0;
    ch_en = 2'b01; x_off = 11'sd0; y_off = 11'sd0; scale_shift = 4'd4;
    vin.hcount = 11'd100; vin.vcount = 11'd300; vin.rgb = BG;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", {20'd0, vout.rgb}, 32'd0);
    check("rst_hcount", {21'd0, vout.hcount}, 32'd0);
    check("rst_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Idle: background passes through with 2-cycle latency
    probe("idle_a", 100, 300, BG);
    check("lat_hcount", {21'd0, vout.hcount}, 32'd100);
    check("lat_vcount", {21'd0, vout.vcount}, 32'd300);
    probe("idle_b", 34, 500, BG);
    ready_check("idle_ready", 1'b0, 1'b1);

    // Ramp 0..255 on ch0 (value<<4), scale 4
    for (int k = 0; k < 256; k++) write_beat(1'b0, 12'(k << 4), (k == 255));
    ready_check("pend_ready", 1'b0, 1'b0);
    ready_check("pend_other_ch", 1'b1, 1'b1);
    probe("ramp_pre_swap", 52, 550, BG);
    vblank_pulse();
    ready_check("swap_ready", 1'b0, 1'b1);
    probe("ramp_k10", 52, 550, C0);
    probe("ramp_k10_seg", 53, 551, C0);
    probe("ramp_above", 52, 549, BG);
    probe("ramp_k100", 232, 460, C0);
    probe("ramp_i0", 32, 560, BG);
    probe("ramp_k255", 542, 305, C0);
    probe("ramp_outside", 544, 304, BG);

    // Overflow: 256 zeros, then a 257th beat with wr_last
    for (int k = 0; k < 256; k++) write_beat(1'b0, 12'd0, 1'b0);
    ready_check("full_ready", 1'b0, 1'b0);
    @(negedge clk);
    wr_valid = 1'b1; wr_ch = 1'b0; wr_data = 12'hFFF; wr_last = 1'b1;
    #1;
    check("beat257_ready", {31'd0, wr_ready}, 32'd0);
    @(posedge clk);
    #1;
    wr_valid = 1'b0; wr_last = 1'b0;
    vblank_pulse();
    probe("full_len256", 542, 560, C0);
    probe("extra_absent", 34, 400, BG);
    probe("full_i1", 34, 560, C0);

    // Step 0 -> 100, scale 0
    scale_shift = 4'd0;
    write_beat(1'b0, 12'd0, 1'b0);
    write_beat(1'b0, 12'd100, 1'b1);
    vblank_pulse();
    probe("step_top", 34, 460, C0);
    probe("step_mid", 35, 510, C0);
    probe("step_bot", 34, 560, C0);
    probe("step_above", 34, 459, BG);
    probe("step_len_end", 36, 500, BG);
    y_off = 11'sd10;
    probe("yoff_lit", 34, 455, C0);
    probe("yoff_below", 34, 555, BG);
    y_off = 11'sd0;
    x_off = 11'sd1;
    probe("xoff_lit", 32, 500, C0);
    x_off = 11'sd0;

    // Two channels with identical data
    write_beat(1'b1, 12'd0, 1'b0);
    write_beat(1'b1, 12'd100, 1'b1);
    ch_en = 2'b10;
    probe("ch1_pre_swap", 34, 500, BG);
    vblank_pulse();
    ch_en = 2'b11;
    probe("prio_ch0", 34, 500, C0);
    ch_en = 2'b10;
    probe("ch1_only", 34, 500, C1);
    ch_en = 2'b00;
    probe("none_en", 34, 500, BG);
    ch_en = 2'b01;

    // wr_last coincident with vblnk rise: swap deferred a frame
    write_beat(1'b0, 12'd0, 1'b0);
    @(negedge clk);
    wr_valid = 1'b1; wr_ch = 1'b0; wr_data = 12'd50; wr_last = 1'b1; vin.vblnk = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0; wr_last = 1'b0;
    @(negedge clk);
    vin.vblnk = 1'b0;
    probe("defer_old", 34, 470, C0);
    vblank_pulse();
    probe("defer_new_above", 34, 470, BG);
    probe("defer_new", 34, 510, C0);

    // Reset while PENDING discards the capture
    write_beat(1'b0, 12'd0, 1'b0);
    write_beat(1'b0, 12'd80, 1'b1);
    ready_check("pend2_ready", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vblank_pulse();
    probe("rst_pend_nodraw", 34, 500, BG);
    ready_check("rst_pend_ready", 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
